// File: rtl/ecc_scrub_ctrl_40_33.sv
// Background ECC scrubber: walks addresses 0..LAST_ADDR, reads each 40-bit word, waits for the
// external 40/33 decoder, writes back corrected data on single errors and logs uncorrectable words.
module ecc_scrub_ctrl_40_33 #(
  parameter int ADDR_W      = 10,
  parameter int LAST_ADDR   = 2**ADDR_W - 1,
  parameter int RD_LATENCY  = 1,
  parameter int DEC_LATENCY = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              stop,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [39:0]       mem_rdata,
  output logic [32:0]       mem_wdata,
  output logic [39:0]       dec_din,
  input  logic [32:0]       dec_dout,
  input  logic              dec_err,
  input  logic              dec_fail,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [15:0]       corr_cnt,
  output logic [15:0]       fail_cnt,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int WAIT_N = RD_LATENCY + DEC_LATENCY;
  localparam int CNT_W  = $clog2(WAIT_N + 1);
  localparam logic [CNT_W-1:0]  WAIT_LD = CNT_W'(WAIT_N);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_WAIT,
    S_WR_REQ,
    S_NEXT
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             stop_lat, stop_lat_nx;
  logic             done_nx, abort_nx;
  logic             clr_pass, addr_inc, sample;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign dec_din = mem_rdata;
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nx    = state;
    stop_lat_nx = stop_lat;
    mem_req     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    done_nx     = 1'b0;
    abort_nx    = 1'b0;
    clr_pass    = 1'b0;
    addr_inc    = 1'b0;
    sample      = 1'b0;
    case (state)
      S_IDLE: begin
        stop_lat_nx = 1'b0;
        if (start) begin
          state_nx = S_RD_REQ;
          clr_pass = 1'b1;
        end
      end
      S_RD_REQ: begin
        mem_req = 1'b1;
        // an abort here beats a same-cycle grant so no read is issued
        if (stop) begin
          state_nx    = S_IDLE;
          abort_nx    = 1'b1;
          stop_lat_nx = 1'b0;
        end else if (mem_gnt) begin
          mem_rd   = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop) stop_lat_nx = 1'b1;
        if (wait_cnt == CNT_W'(1)) begin
          sample   = 1'b1;
          state_nx = (dec_err && !dec_fail) ? S_WR_REQ : S_NEXT;
        end
      end
      S_WR_REQ: begin
        mem_req = 1'b1;
        if (stop) stop_lat_nx = 1'b1;
        if (mem_gnt) begin
          mem_wr   = 1'b1;
          state_nx = S_NEXT;
        end
      end
      S_NEXT: begin
        stop_lat_nx = 1'b0;
        if (stop_lat || stop) begin
          state_nx = S_IDLE;
          abort_nx = 1'b1;
        end else if (mem_addr == LAST) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
          addr_inc = 1'b1;
          state_nx = S_RD_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= S_IDLE;
      stop_lat <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      stop_lat <= stop_lat_nx;
      done     <= done_nx;
      aborted  <= abort_nx;
      if (mem_rd)
        wait_cnt <= WAIT_LD;
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      corr_cnt  <= '0;
      fail_cnt  <= '0;
      fail_addr <= '0;
    end else if (clr_pass) begin
      mem_addr  <= '0;
      corr_cnt  <= '0;
      fail_cnt  <= '0;
      fail_addr <= '0;
    end else begin
      if (addr_inc) mem_addr <= mem_addr + ADDR_W'(1);
      if (sample && dec_err) begin
        if (dec_fail) begin
          fail_cnt  <= sat_inc(fail_cnt);
          fail_addr <= mem_addr;
        end else begin
          corr_cnt  <= sat_inc(corr_cnt);
          mem_wdata <= dec_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl_40_33.sv
// Bench for ecc_scrub_ctrl_40_33: memory/decoder model with a fixed-latency result pipe and a
// pass-level reference (reads, write-backs, counters) derived from per-word error types.
module tb_ecc_scrub_ctrl_40_33;
  localparam int ADDR_W = 4;
  localparam int LAST   = 3;

  logic              clk, arst, start, stop, mem_gnt, dec_err, dec_fail;
  logic [39:0]       mem_rdata, dec_din;
  logic [32:0]       dec_dout, mem_wdata;
  logic              mem_req, mem_rd, mem_wr, busy, done, aborted;
  logic [ADDR_W-1:0] mem_addr, fail_addr;
  logic [15:0]       corr_cnt, fail_cnt;

  ecc_scrub_ctrl_40_33 #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST), .RD_LATENCY(1), .DEC_LATENCY(4)) dut (
    .clk(clk), .arst(arst), .start(start), .stop(stop),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .dec_din(dec_din), .dec_dout(dec_dout), .dec_err(dec_err), .dec_fail(dec_fail),
    .busy(busy), .done(done), .aborted(aborted),
    .corr_cnt(corr_cnt), .fail_cnt(fail_cnt), .fail_addr(fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          etype[16];
  logic [32:0] dword[16];
  bit          pv[5];
  int          pa[5];
  int          gnt_mode;
  int          rd_q[$];
  int          wa_q[$];
  logic [32:0] wd_q[$];
  int          done_cnt, abort_cnt, last_rd;

  typedef struct {
    int e0, e1, e2, e3;
    int corr, fail, faddr, nwr, rg;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_log();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    done_cnt  = 0;
    abort_cnt = 0;
  endtask

  task automatic set_words(input int e0, input int e1, input int e2, input int e3);
    for (int i = 0; i < 16; i++) begin
      etype[i] = 0;
      dword[i] = {1'($urandom), $urandom};
    end
    etype[0] = e0;
    etype[1] = e1;
    etype[2] = e2;
    etype[3] = e3;
  endtask

  // One clock cycle: drive inputs at the falling edge, let logic settle, then observe and log.
  task automatic step(input logic st, input logic sp);
    @(negedge clk);
    start = st;
    stop  = sp;
    case (gnt_mode)
      0:       mem_gnt = 1'b1;
      1:       mem_gnt = 1'($urandom);
      default: mem_gnt = 1'b0;
    endcase
    mem_rdata = pv[0] ? {7'h2a, dword[pa[0]]} : {8'($urandom), $urandom};
    if (pv[4]) begin
      dec_err  = (etype[pa[4]] != 0);
      dec_fail = (etype[pa[4]] == 2);
      dec_dout = dword[pa[4]];
    end else begin
      dec_err  = 1'($urandom);
      dec_fail = 1'($urandom);
      dec_dout = {1'($urandom), $urandom};
    end
    #1;
    chk("rd_wr_exclusive", 64'(mem_rd & mem_wr), 64'(0));
    chk("strobe_needs_req_gnt", 64'((mem_rd | mem_wr) & ~(mem_req & mem_gnt)), 64'(0));
    chk("dec_din_passthru", 64'(dec_din), 64'(mem_rdata));
    if (mem_wr) begin
      chk("wr_addr_stable", 64'(mem_addr), 64'(last_rd));
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(mem_wdata);
    end
    if (mem_rd) begin
      rd_q.push_back(int'(mem_addr));
      last_rd = int'(mem_addr);
    end
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
    for (int k = 4; k > 0; k--) begin
      pv[k] = pv[k-1];
      pa[k] = pa[k-1];
    end
    pv[0] = mem_rd;
    pa[0] = int'(mem_addr);
  endtask

  task automatic run_to_end(input bit rs);
    int   n = 0;
    logic st;
    while (done_cnt == 0 && abort_cnt == 0 && n < 200) begin
      st = rs && busy && (int'(mem_addr) < LAST) && ($urandom_range(0, 7) == 0);
      step(st, 1'b0);
      n++;
    end
    if (done_cnt == 0 && abort_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL pass_timeout: no done/aborted after %0d cycles, required within 200", n);
    end
  endtask

  // Reference for a complete pass: every address read once in order, singles written back
  // with corrected data, doubles counted with the highest failing address remembered.
  task automatic check_pass(input string tag);
    int ncorr = 0;
    int nfail = 0;
    int faddr = 0;
    int wexp[$];
    for (int a = 0; a <= LAST; a++) begin
      if (etype[a] == 1) begin
        ncorr++;
        wexp.push_back(a);
      end else if (etype[a] == 2) begin
        nfail++;
        faddr = a;
      end
    end
    chk({tag, "_nreads"}, 64'(rd_q.size()), 64'(LAST + 1));
    for (int i = 0; i < rd_q.size() && i <= LAST; i++)
      chk({tag, "_rd_addr"}, 64'(rd_q[i]), 64'(i));
    chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'(wexp.size()));
    for (int i = 0; i < wa_q.size() && i < wexp.size(); i++) begin
      chk({tag, "_wr_addr"}, 64'(wa_q[i]), 64'(wexp[i]));
      chk({tag, "_wr_data"}, 64'(wd_q[i]), 64'(dword[wexp[i]]));
    end
    chk({tag, "_corr_cnt"}, 64'(corr_cnt), 64'(ncorr));
    chk({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(nfail));
    chk({tag, "_fail_addr"}, 64'(fail_addr), 64'(faddr));
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
    chk({tag, "_abort_pulses"}, 64'(abort_cnt), 64'(0));
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  task automatic stop_in_wait(input int w, input string tag);
    int n = 0;
    int ncorr = 0;
    int nfail = 0;
    clear_log();
    gnt_mode = 0;
    step(1'b1, 1'b0);
    while (rd_q.size() < w + 1 && n < 50) begin
      step(1'b0, 1'b0);
      n++;
    end
    step(1'b0, 1'b1);
    n = 0;
    while (done_cnt == 0 && abort_cnt == 0 && n < 50) begin
      step(1'b0, 1'b0);
      n++;
    end
    for (int a = 0; a <= w; a++) begin
      if (etype[a] == 1) ncorr++;
      if (etype[a] == 2) nfail++;
    end
    chk({tag, "_aborted"}, 64'(abort_cnt), 64'(1));
    chk({tag, "_no_done"}, 64'(done_cnt), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'(ncorr));
    chk({tag, "_corr_cnt"}, 64'(corr_cnt), 64'(ncorr));
    chk({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(nfail));
    repeat (3) step(1'b0, 1'b0);
    chk({tag, "_nreads"}, 64'(rd_q.size()), 64'(w + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 1, 0, 0, 1, 0};
    tbl[2] = '{0, 2, 0, 0, 0, 1, 1, 0, 0};
    tbl[3] = '{1, 2, 1, 2, 2, 2, 3, 2, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{2, 2, 2, 2, 0, 4, 3, 0, 0};
    tbl[6] = '{1, 1, 1, 1, 4, 0, 0, 4, 1};

    arst = 1'b1; start = 1'b0; stop = 1'b0; mem_gnt = 1'b1;
    dec_err = 1'b0; dec_fail = 1'b0; dec_dout = '0; mem_rdata = '0;
    gnt_mode = 0; last_rd = 0;
    for (int k = 0; k < 5; k++) begin
      pv[k] = 1'b0;
      pa[k] = 0;
    end
    set_words(0, 0, 0, 0);
    clear_log();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_strobes", 64'({mem_rd, mem_wr}), 64'(0));
    chk("rst_flags", 64'({busy, done, aborted}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_counts", 64'({corr_cnt, fail_cnt, fail_addr}), 64'(0));

    // start asserted together with reset release must be taken on the very next edge
    @(negedge clk);
    arst  = 1'b0;
    start = 1'b1;
    step(1'b0, 1'b0);
    chk("first_start_busy", 64'(busy), 64'(1));
    run_to_end(1'b0);
    check_pass("first_pass");

    for (int t = 0; t < 7; t++) begin
      set_words(tbl[t].e0, tbl[t].e1, tbl[t].e2, tbl[t].e3);
      gnt_mode = tbl[t].rg;
      clear_log();
      step(1'b1, 1'b0);
      run_to_end(1'b0);
      check_pass("tbl");
      chk("tbl_corr", 64'(corr_cnt), 64'(tbl[t].corr));
      chk("tbl_fail", 64'(fail_cnt), 64'(tbl[t].fail));
      chk("tbl_faddr", 64'(fail_addr), 64'(tbl[t].faddr));
      chk("tbl_nwr", 64'(wa_q.size()), 64'(tbl[t].nwr));
      repeat (3) step(1'b0, 1'b0);
      chk("idle_hold_counts", 64'({corr_cnt, fail_cnt, fail_addr}),
          64'({16'(tbl[t].corr), 16'(tbl[t].fail), ADDR_W'(tbl[t].faddr)}));
    end

    // grant withheld in both request states
    clear_log();
    set_words(1, 0, 0, 0);
    gnt_mode = 2;
    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      chk("nogrant_rd_req", 64'(mem_req), 64'(1));
      chk("nogrant_rd_strobe", 64'(mem_rd), 64'(0));
      chk("nogrant_rd_addr", 64'(mem_addr), 64'(0));
    end
    gnt_mode = 0;
    step(1'b0, 1'b0);
    chk("grant_rd_strobe", 64'(mem_rd), 64'(1));
    gnt_mode = 2;
    step(1'b0, 1'b0);
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      step(1'b0, 1'b0);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("nogrant_wr_req", 64'(mem_req), 64'(1));
      chk("nogrant_wr_strobe", 64'(mem_wr), 64'(0));
      chk("nogrant_wr_addr", 64'(mem_addr), 64'(0));
      chk("nogrant_wr_data", 64'(mem_wdata), 64'(dword[0]));
      step(1'b0, 1'b0);
    end
    gnt_mode = 0;
    step(1'b0, 1'b0);
    chk("grant_wr_strobe", 64'(mem_wr), 64'(1));
    run_to_end(1'b0);
    check_pass("gnt_hold");

    set_words(0, 1, 0, 0);
    stop_in_wait(1, "stop_w1");
    set_words(0, 0, 2, 1);
    stop_in_wait(3, "stop_last");

    // stop in RD_REQ, same cycle as grant
    clear_log();
    gnt_mode = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("stop_gnt_req", 64'(mem_req), 64'(1));
    chk("stop_gnt_no_rd", 64'(mem_rd), 64'(0));
    step(1'b0, 1'b0);
    chk("stop_gnt_aborted", 64'(aborted), 64'(1));
    chk("stop_gnt_idle", 64'({busy, done}), 64'(0));
    chk("stop_gnt_nreads", 64'(rd_q.size()), 64'(0));
    step(1'b0, 1'b0);
    chk("abort_one_cycle", 64'(aborted), 64'(0));

    // stop in RD_REQ before any grant
    clear_log();
    gnt_mode = 2;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("stop_nogrant_aborted", 64'(aborted), 64'(1));
    chk("stop_nogrant_busy", 64'(busy), 64'(0));

    // start and stop together in IDLE: start wins
    clear_log();
    set_words(0, 1, 0, 2);
    gnt_mode = 1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("start_stop_busy", 64'(busy), 64'(1));
    chk("start_stop_no_abort", 64'(aborted), 64'(0));
    run_to_end(1'b0);
    check_pass("start_stop");

    // asynchronous reset while waiting on word 1
    clear_log();
    set_words(1, 0, 0, 0);
    gnt_mode = 0;
    step(1'b1, 1'b0);
    n = 0;
    while (rd_q.size() < 2 && n < 50) begin
      step(1'b0, 1'b0);
      n++;
    end
    step(1'b0, 1'b0);
    chk("pre_rst_corr", 64'(corr_cnt), 64'(1));
    arst = 1'b1;
    #1;
    chk("arst_mem_req", 64'(mem_req), 64'(0));
    chk("arst_strobes", 64'({mem_rd, mem_wr}), 64'(0));
    chk("arst_flags", 64'({busy, done, aborted}), 64'(0));
    chk("arst_mem_addr", 64'(mem_addr), 64'(0));
    chk("arst_wdata", 64'(mem_wdata), 64'(0));
    chk("arst_counts", 64'({corr_cnt, fail_cnt, fail_addr}), 64'(0));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("arst_no_pulses", 64'(done_cnt + abort_cnt), 64'(0));
    @(negedge clk);
    arst = 1'b0;
    clear_log();
    set_words(0, 0, 0, 0);
    start = 1'b1;
    step(1'b0, 1'b0);
    chk("restart_busy", 64'(busy), 64'(1));
    run_to_end(1'b0);
    check_pass("restart");

    for (int r = 0; r < 20; r++) begin
      set_words(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      gnt_mode = int'($urandom_range(0, 1));
      clear_log();
      step(1'b1, 1'b0);
      run_to_end(1'b1);
      check_pass("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc_scrub_ctrl_40_33.md
ECC_SCRUB_CTRL_40_33 -- requirements
Module: ecc_scrub_ctrl_40_33

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width.
REQ-002 Parameter LAST_ADDR, default 2**ADDR_W-1, final address of a scrub pass.
REQ-003 Parameter RD_LATENCY, default 1, cycles from mem_rd to mem_rdata valid (range 1..4).
REQ-004 Parameter DEC_LATENCY, default 4, cycles from dec_din to dec_dout/dec_err/dec_fail valid.
REQ-005 Ports: clk  in  1  sole clock; all logic on posedge clk.
REQ-006 Ports: arst  in  1  asynchronous, active-high reset.
REQ-007 Ports: start  in  1  begin a scrub pass at address 0; stop  in  1  abort request.
REQ-008 Ports: mem_req  out  1  memory port request; mem_gnt  in  1  grant, same-cycle.
REQ-009 Ports: mem_rd  out  1  read strobe; mem_wr  out  1  write strobe; mem_addr  out  ADDR_W  word address.
REQ-010 Ports: mem_rdata  in  40  raw ECC word; mem_wdata  out  33  corrected data to the external encoder/write path.
REQ-011 Ports: dec_din  out  40  to 40/33 decoder; dec_dout  in  33; dec_err  in  1  any error; dec_fail  in  1  uncorrectable.
REQ-012 Ports: busy  out  1; done  out  1  pass-complete pulse; aborted  out  1  abort pulse.
REQ-013 Ports: corr_cnt  out  16; fail_cnt  out  16; fail_addr  out  ADDR_W  address of most recent uncorrectable word.

Function
REQ-014 dec_din SHALL equal mem_rdata combinationally.
REQ-015 FSM states: IDLE, RD_REQ, WAIT, WR_REQ, NEXT; busy = (state != IDLE).
REQ-016 IDLE: start=1 -> RD_REQ, mem_addr<=0, corr_cnt<=0, fail_cnt<=0, fail_addr<=0; start while busy SHALL be ignored.
REQ-017 RD_REQ: mem_req=1; mem_rd = mem_gnt; on mem_gnt -> WAIT with wait counter loaded to RD_LATENCY+DEC_LATENCY; without grant remain, mem_rd=0.
REQ-018 WAIT: counter decrements each cycle; decoder outputs SHALL be sampled exactly RD_LATENCY+DEC_LATENCY cycles after the mem_rd cycle (default 5).
REQ-019 Sample decision: dec_err=0 -> NEXT; dec_err=1,dec_fail=0 -> WR_REQ, corr_cnt+1, capture dec_dout; dec_fail=1 -> NEXT, fail_cnt+1, fail_addr<=mem_addr, no write.
REQ-020 WR_REQ: mem_req=1, mem_addr unchanged, mem_wdata = captured word; mem_wr = mem_gnt; on grant -> NEXT.
REQ-021 mem_rd and mem_wr SHALL never both be 1, and each SHALL be 1 only with mem_req=1 and mem_gnt=1.
REQ-022 NEXT: mem_addr==LAST_ADDR -> IDLE with done=1 for one cycle; else mem_addr+1 -> RD_REQ.
REQ-023 mem_addr SHALL hold stable from RD_REQ through WR_REQ of a word.
REQ-024 corr_cnt and fail_cnt SHALL saturate at 16'hFFFF, no wrap.
REQ-025 stop in RD_REQ before grant (or same cycle as grant, stop wins, mem_rd=0) -> IDLE, aborted=1 one cycle.
REQ-026 stop in WAIT/WR_REQ SHALL be latched; current word completes (including write-back); then IDLE with aborted=1, done=0.
REQ-027 stop and start together in IDLE: start wins, stop ignored.
REQ-028 stop latched when the last word completes: aborted=1, done=0.
REQ-029 Counters and fail_addr SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-030 arst=1 SHALL immediately force state IDLE, mem_req/mem_rd/mem_wr/busy/done/aborted=0, mem_addr=0, mem_wdata=0, corr_cnt=0, fail_cnt=0, fail_addr=0, stop latch cleared.
REQ-031 arst asserted mid-pass SHALL abandon the pass with no done/aborted pulse; in-flight decoder results SHALL be ignored after release.
REQ-032 First start SHALL be honoured on the first clock edge after arst deasserts.

Verification
REQ-033 LAST_ADDR=3, mem_gnt=1, all words clean, start pulse -> 4 reads at addr 0..3, no writes, done pulse, counts 0/0.
REQ-034 Word 2 single-bit error (dec_err=1,dec_fail=0) -> mem_wr at addr 2 with corrected data, corr_cnt=1.
REQ-035 Word 1 double error (dec_err=1,dec_fail=1) -> no write, fail_cnt=1, fail_addr=1, pass continues to done.
REQ-036 mem_gnt held 0 for 10 cycles in RD_REQ and WR_REQ -> mem_rd/mem_wr stay 0, mem_addr stable, completes on grant.
REQ-037 stop during WAIT of word 1 -> word 1 finishes, aborted pulse, done=0, busy=0, no read of addr 2.
REQ-038 arst pulsed in WAIT -> all outputs at reset values at once; restart runs a full clean pass.
